// File: rtl/datapath_sequencer.sv
// Sequencer for the single-cycle RISC-V datapath: owns the PC, holds the datapath
// in reset during init, and runs it free, paused/single-stepped or until a stop condition.
module datapath_sequencer #(
    parameter logic [63:0] RESET_PC    = 64'h000000000000000A,
    parameter int          INIT_CYCLES = 2,
    parameter int          MAX_INSTR   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_mode,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        step,
    input  logic [63:0] dp_new_pc,
    input  logic [31:0] dp_instruction,
    input  logic [63:0] dp_result,
    output logic [63:0] pc,
    output logic        dp_reset,
    output logic        busy,
    output logic        done,
    output logic [2:0]  stop_reason,
    output logic [31:0] retired_count,
    output logic [63:0] last_result
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [2:0]  RS_NONE      = 3'd0;
    localparam logic [2:0]  RS_ECALL     = 3'd1;
    localparam logic [2:0]  RS_ZERO      = 3'd2;
    localparam logic [2:0]  RS_LIMIT     = 3'd3;
    localparam logic [2:0]  RS_SELF_LOOP = 3'd4;
    localparam logic [31:0] ECALL_WORD   = 32'h00000073;
    localparam logic [31:0] MAX_COUNT    = 32'(MAX_INSTR);
    localparam logic [3:0]  INIT_LAST    = 4'(INIT_CYCLES - 1);

    state_t      state_reg;
    logic        step_mode_reg;
    logic [3:0]  init_cnt_reg;
    logic [63:0] pc_reg;
    logic        dp_reset_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [2:0]  stop_reason_reg;
    logic [31:0] retired_count_reg;
    logic [63:0] last_result_reg;

    // Decode of the current execute cycle; only acted upon when exec_en is high.
    logic       exec_en;
    logic       commit;
    logic       stop_now;
    logic [2:0] stop_code;

    always_comb begin
        exec_en = ((state_reg == ST_RUN) && !halt_req) ||
                  ((state_reg == ST_PAUSE) && step);
    end

    always_comb begin
        commit    = 1'b0;
        stop_now  = 1'b0;
        stop_code = RS_NONE;
        if (retired_count_reg == MAX_COUNT) begin
            stop_now  = 1'b1;
            stop_code = RS_LIMIT;
        end else if (dp_instruction == ECALL_WORD) begin
            stop_now  = 1'b1;
            stop_code = RS_ECALL;
        end else if (dp_instruction == 32'h00000000) begin
            stop_now  = 1'b1;
            stop_code = RS_ZERO;
        end else begin
            commit = 1'b1;
            // A branch to itself would spin forever, so retire it and then stop.
            if (dp_new_pc == pc_reg) begin
                stop_now  = 1'b1;
                stop_code = RS_SELF_LOOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            step_mode_reg     <= 1'b0;
            init_cnt_reg      <= 4'd0;
            pc_reg            <= RESET_PC;
            dp_reset_reg      <= 1'b1;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            stop_reason_reg   <= RS_NONE;
            retired_count_reg <= 32'd0;
            last_result_reg   <= 64'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg         <= ST_INIT;
                        step_mode_reg     <= step_mode;
                        init_cnt_reg      <= 4'd0;
                        pc_reg            <= RESET_PC;
                        retired_count_reg <= 32'd0;
                        stop_reason_reg   <= RS_NONE;
                        dp_reset_reg      <= 1'b1;
                        busy_reg          <= 1'b1;
                        done_reg          <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (init_cnt_reg == INIT_LAST) begin
                        state_reg    <= step_mode_reg ? ST_PAUSE : ST_RUN;
                        dp_reset_reg <= 1'b0;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + 4'd1;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (exec_en) begin
                        if (commit) begin
                            pc_reg            <= dp_new_pc;
                            retired_count_reg <= retired_count_reg + 32'd1;
                            last_result_reg   <= dp_result;
                        end
                        if (stop_now) begin
                            state_reg       <= ST_DONE;
                            stop_reason_reg <= stop_code;
                            busy_reg        <= 1'b0;
                            done_reg        <= 1'b1;
                        end
                    end else if (state_reg == ST_RUN) begin
                        // Not executing in RUN can only mean halt_req is high.
                        state_reg <= ST_PAUSE;
                    end else if (resume) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc            = pc_reg;
    assign dp_reset      = dp_reset_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign stop_reason   = stop_reason_reg;
    assign retired_count = retired_count_reg;
    assign last_result   = last_result_reg;

endmodule
